rr_fifo_mux: RTL and testbench

// - N-channel ingress buffer with a round-robin merge. Each channel owns a private FIFO of depth 2**LOG_DEPTH.
// - One registered valid/ready output carries one entry per cycle, tagged with its source channel.
// - Sits where several producers (tiles, task units, debug taps) funnel into one consumer port.
// - Successor to the single-queue FIFO + rr_sched pairing: adds channel count, per-channel occupancy and almost-full flags.

---
 rtl/rr_fifo_mux.sv | 193 +++++++++++++++++++
 tb/tb_rr_fifo_mux.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_fifo_mux.sv
// Per-channel FIFO: pointer-based storage with a registered occupancy count and almost-full flag.
// Latency: an entry pushed at edge t becomes the head (empty deasserts) after edge t.
// Backpressure: full depends only on stored pointers; the caller must not push while full.
module rr_fifo_mux_fifo #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2,
    parameter int AF_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wr_dat,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rd_dat,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   level,
    output logic                 afull
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int PW    = LOG_DEPTH + 1;
    localparam logic [PW-1:0] AF_LIM = PW'(AF_THRESH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic             afull_q, afull_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Pointers carry one extra wrap bit so equal low bits with differing MSB means full.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                    (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
    assign rd_dat = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
    assign level  = level_q;
    assign afull  = afull_q;

    // Next pointer, occupancy and storage contents for this edge's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + PW'(push) - PW'(pop);
        afull_d  = (level_d >= AF_LIM);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[LOG_DEPTH-1:0]] = wr_dat;
        end
    end

    // Control state; clearing the pointers discards every stored entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            afull_q  <= afull_d;
        end
    end

    // Payload storage needs no reset: validity is carried by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// N-channel ingress buffer merged round-robin into one registered valid/ready output tagged with its channel.
// Latency: push accepted at edge t into an idle path appears on m_valid after edge t+1; no s_* -> m_* comb path.
// Backpressure: s_ready per channel from stored fullness only; m_ready low freezes the output register.
module rr_fifo_mux #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2,
    parameter int N_CH      = 4,
    parameter int LOG_N     = 2,
    parameter int AF_THRESH = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_CH-1:0]               s_valid,
    input  logic [N_CH*WIDTH-1:0]         s_data,
    output logic [N_CH-1:0]               s_ready,
    output logic                          m_valid,
    output logic [WIDTH-1:0]              m_data,
    output logic [LOG_N-1:0]              m_chan,
    input  logic                          m_ready,
    output logic [N_CH*(LOG_DEPTH+1)-1:0] ch_size,
    output logic [N_CH-1:0]               ch_afull
);
    localparam int PW = LOG_DEPTH + 1;

    logic                en_q, en_d;
    logic [N_CH-1:0]     fifo_empty;
    logic [N_CH-1:0]     fifo_full;
    logic [N_CH-1:0]     push;
    logic [N_CH-1:0]     pop;
    logic [WIDTH-1:0]    head [N_CH];
    logic                ld;
    logic                win_vld;
    logic [LOG_N-1:0]    win;
    int                  idx;
    logic                m_valid_q, m_valid_d;
    logic [WIDTH-1:0]    m_data_q, m_data_d;
    logic [LOG_N-1:0]    m_chan_q, m_chan_d;
    logic [LOG_N-1:0]    last_sel_q, last_sel_d;

    // The output register may take a new entry when empty or being drained this cycle.
    assign ld = !m_valid_q || m_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign s_ready[g] = en_q & ~fifo_full[g];
        assign push[g]    = s_valid[g] & s_ready[g];
        assign pop[g]     = ld & win_vld & (win == LOG_N'(g));

        rr_fifo_mux_fifo #(
            .WIDTH     (WIDTH),
            .LOG_DEPTH (LOG_DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo (
            .clk    (clk),
            .rstn   (rstn),
            .push   (push[g]),
            .wr_dat (s_data[g*WIDTH +: WIDTH]),
            .pop    (pop[g]),
            .rd_dat (head[g]),
            .empty  (fifo_empty[g]),
            .full   (fifo_full[g]),
            .level  (ch_size[g*PW +: PW]),
            .afull  (ch_afull[g])
        );
    end

    // Round-robin pick: first non-empty channel scanning upward from the one after the last winner.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last_sel_q) + k) % N_CH;
            if (!win_vld && !fifo_empty[idx]) begin
                win_vld = 1'b1;
                win     = LOG_N'(idx);
            end
        end
    end

    // Output register and arbitration pointer advance only on a load.
    always_comb begin
        en_d       = 1'b1;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_chan_d   = m_chan_q;
        last_sel_d = last_sel_q;
        if (ld) begin
            m_valid_d = win_vld;
            if (win_vld) begin
                m_data_d   = head[win];
                m_chan_d   = win;
                last_sel_d = win;
            end
        end
    end

    // State registers; en_q holds s_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q       <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_chan_q   <= '0;
            last_sel_q <= LOG_N'(N_CH - 1);
        end else begin
            en_q       <= en_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_chan_q   <= m_chan_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_chan  = m_chan_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
        (push & fifo_full) == '0);
    a_winner_nonempty: assert property (@(posedge clk) disable iff (!rstn)
        (ld && win_vld) |-> !fifo_empty[win]);
endmodule

// File: tb/tb_rr_fifo_mux.sv
module tb_rr_fifo_mux;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   s_valid;
    logic [127:0] s_data;
    logic [3:0]   s_ready;
    logic         m_valid;
    logic [31:0]  m_data;
    logic [1:0]   m_chan;
    logic         m_ready;
    logic [11:0]  ch_size;
    logic [3:0]   ch_afull;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    rr_fifo_mux #(
        .WIDTH(32), .LOG_DEPTH(2), .N_CH(4), .LOG_N(2), .AF_THRESH(3)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_chan(m_chan), .m_ready(m_ready),
        .ch_size(ch_size), .ch_afull(ch_afull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_dat(input int ch, input logic [31:0] v);
        s_data[ch*32 +: 32] = v;
    endtask

    // Reference model: per-channel queues of stored entries, the output register, and the last winner.
    logic [31:0] mq [4][$];
    bit          ov;
    logic [1:0]  oc;
    logic [31:0] od;
    int          last;
    bit          men;
    int          sz [4];
    bit          found;
    int          w;

    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            ov = 0; oc = 0; od = 0; last = 3; men = 0;
            chk("mdl_rst_m_valid", m_valid, 0);
            chk("mdl_rst_ch_size", ch_size, 0);
        end else begin
            chk("mdl_m_valid", m_valid, ov);
            if (ov) begin
                chk("mdl_m_chan", m_chan, oc);
                chk("mdl_m_data", m_data, od);
            end
            for (int i = 0; i < 4; i++) begin
                sz[i] = mq[i].size();
                chk("mdl_ch_size", ch_size[i*3 +: 3], sz[i]);
                chk("mdl_ch_afull", ch_afull[i], sz[i] >= 3);
                chk("mdl_s_ready", s_ready[i], men && sz[i] < 4);
            end
            if (!ov || m_ready) begin
                found = 0;
                w = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && mq[(last + k) % 4].size() > 0) begin
                        found = 1;
                        w = (last + k) % 4;
                    end
                end
                if (found) begin
                    od = mq[w].pop_front();
                    oc = w[1:0];
                    ov = 1;
                    last = w;
                end else begin
                    ov = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (s_valid[i] && men && sz[i] < 4) mq[i].push_back(s_data[i*32 +: 32]);
            end
            men = 1;
        end
    end

    logic [1:0]  seq [$];
    logic [31:0] got [$];
    int          first_i, last_i;

    initial begin
        s_valid = 0; s_data = 0; m_ready = 0;
        cyc(3);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_chan", m_chan, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_ch_afull", ch_afull, 0);
        chk("rst_ch_size", ch_size, 0);

        // Reset release with every channel requesting.
        for (int i = 0; i < 4; i++) set_dat(i, 32'h100 + i);
        s_valid = 4'hF; m_ready = 1; rstn = 1;
        #1 chk("rel_s_ready_first", s_ready, 4'h0);
        cyc(1);
        chk("rel_s_ready_on", s_ready, 4'hF);
        chk("rel_m_valid_pre", m_valid, 0);
        cyc(1);
        s_valid = 0;
        chk("rel_m_valid_accept", m_valid, 0);
        chk("rel_ch_size", ch_size, 12'h249);
        cyc(1);
        chk("rel_m_valid", m_valid, 1);
        chk("rel_m_chan", m_chan, 0);
        chk("rel_m_data", m_data, 32'h100);
        cyc(6);

        // Only channels 1 and 3 loaded.
        first_i = -1; last_i = -1;
        for (int c = 0; c < 14; c++) begin
            if (m_valid) begin
                seq.push_back(m_chan);
                if (first_i < 0) first_i = c;
                last_i = c;
            end
            if (c < 3) begin
                set_dat(1, 32'h1100 + c);
                set_dat(3, 32'h3300 + c);
                s_valid = 4'b1010;
            end else begin
                s_valid = 0;
            end
            cyc(1);
        end
        chk("skip_count", seq.size(), 6);
        for (int k = 0; k < seq.size(); k++) chk("skip_chan", seq[k], (k % 2 == 0) ? 1 : 3);
        chk("skip_contig", last_i - first_i, 5);
        chk("skip_idle", m_valid, 0);

        // Fairness with all channels kept busy.
        for (int c = 0; c <= 16; c++) begin
            s_valid = 4'hF;
            for (int i = 0; i < 4; i++) set_dat(i, $urandom);
            cyc(1);
            if (c >= 1) begin
                chk("fair_valid", m_valid, 1);
                chk("fair_chan", m_chan, (c - 1) % 4);
            end
        end
        s_valid = 0;
        cyc(20);

        // Backpressure on channel 0 with 0xA5 held at the output.
        m_ready = 0;
        set_dat(0, 32'hA5); s_valid = 4'b0001;
        cyc(1);
        set_dat(0, 32'hB1);
        cyc(1);
        for (int k = 0; k < 10; k++) begin
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, 32'hA5);
            chk("bp_m_chan", m_chan, 0);
            chk("bp_size", ch_size[2:0], (k + 1 < 4) ? k + 1 : 4);
            chk("bp_afull", ch_afull[0], k >= 2);
            set_dat(0, 32'hB2 + k);
            cyc(1);
        end
        chk("bp_full_size", ch_size[2:0], 4);
        chk("bp_s_ready", s_ready[0], 0);
        s_valid = 0; m_ready = 1;
        cyc(8);

        // Channel 2 full while the output drains it.
        m_ready = 0; s_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            set_dat(2, 32'hC0 + k);
            cyc(1);
        end
        chk("fp_full_size", ch_size[8:6], 4);
        chk("fp_full_ready", s_ready[2], 0);
        set_dat(2, 32'hC5); m_ready = 1;
        cyc(1);
        chk("fp_pop_size", ch_size[8:6], 3);
        chk("fp_pop_ready", s_ready[2], 1);
        chk("fp_pop_data", m_data, 32'hC1);
        cyc(1);
        s_valid = 0;
        chk("fp_push_size", ch_size[8:6], 3);
        chk("fp_push_data", m_data, 32'hC2);
        cyc(8);

        // Streaming 20 entries through channel 1 across pointer wraps.
        for (int c = 0; c < 26; c++) begin
            if (m_valid) got.push_back(m_data);
            if (c < 20) begin
                set_dat(1, c);
                s_valid = 4'b0010;
            end else begin
                s_valid = 0;
            end
            cyc(1);
        end
        chk("wrap_count", got.size(), 20);
        for (int k = 0; k < got.size(); k++) chk("wrap_data", got[k], k);

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            s_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) set_dat(i, $urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        // Reset dropped mid-stream.
        m_ready = 0; s_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_dat(i, 32'hDEAD0000 + i);
        cyc(3);
        chk("mr_pre_valid", m_valid, 1);
        #2 rstn = 0;
        #1;
        chk("mr_m_valid", m_valid, 0);
        chk("mr_ch_size", ch_size, 0);
        chk("mr_s_ready", s_ready, 0);
        s_valid = 0; m_ready = 1;
        cyc(2);
        rstn = 1;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk("mr_no_stale_valid", m_valid, 0);
            chk("mr_no_stale_size", ch_size, 0);
        end
        set_dat(3, 32'h77); s_valid = 4'b1000;
        cyc(1);
        s_valid = 0;
        cyc(1);
        chk("mr_after_valid", m_valid, 1);
        chk("mr_after_chan", m_chan, 3);
        chk("mr_after_data", m_data, 32'h77);
        cyc(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
